// File: rtl/rally_sequencer.sv
// Rally sequencer for a two-player volley game: serve, touch-count faults,
// ground scoring, post-point pause and end-of-match handling.
module rally_sequencer #(
    parameter int NET_X        = 512,
    parameter int WIN_SCORE    = 15,
    parameter int MAX_TOUCH    = 3,
    parameter int PAUSE_FRAMES = 120,
    parameter int P1_SERVE_X   = 200,
    parameter int P2_SERVE_X   = 824
) (
    input  logic        pclk,
    input  logic        rst,
    input  logic        frame_tick,
    input  logic        pl1_click,
    input  logic        pl2_click,
    input  logic        pl1_col,
    input  logic        pl2_col,
    input  logic        gnd_col,
    input  logic [11:0] ball_xpos,
    output logic [2:0]  state,
    output logic        ball_hold,
    output logic        ball_freeze,
    output logic        serve_side,
    output logic [11:0] serve_posx,
    output logic [4:0]  score_p1,
    output logic [4:0]  score_p2,
    output logic        point_pulse,
    output logic        endgame,
    output logic        winner
);

    localparam int PW = $clog2(PAUSE_FRAMES + 1);
    localparam logic [PW-1:0] PAUSE_L = PW'(PAUSE_FRAMES);
    localparam logic [11:0]   NET_L   = 12'(NET_X);
    localparam logic [4:0]    WIN_L   = 5'(WIN_SCORE);
    localparam logic [3:0]    MAXT_L  = 4'(MAX_TOUCH);

    typedef enum logic [2:0] {
        S_SERVE = 3'd0,
        S_PLAY  = 3'd1,
        S_POINT = 3'd2,
        S_OVER  = 3'd3
    } state_t;

    state_t          state_q, state_d;
    logic [2:0]      t1_q, t2_q, t1_d, t2_d;
    logic [PW-1:0]   pause_q;
    logic [4:0]      s1_q, s2_q;
    logic            serve_q, scorer_q, winner_q, pulse_q;
    logic [4:0]      hist_q, now, ev;
    logic            award, award_p2;
    logic [3:0]      t1_inc, t2_inc;

    // Bit order: gnd_col, pl2_col, pl1_col, pl2_click, pl1_click.
    assign now    = {gnd_col, pl2_col, pl1_col, pl2_click, pl1_click};
    assign ev     = now & ~hist_q;
    assign t1_inc = {1'b0, t1_q} + 4'd1;
    assign t2_inc = {1'b0, t2_q} + 4'd1;

    always_comb begin
        state_d  = state_q;
        award    = 1'b0;
        award_p2 = 1'b0;
        t1_d     = t1_q;
        t2_d     = t2_q;
        case (state_q)
            S_SERVE: begin
                if (serve_q ? ev[1] : ev[0]) state_d = S_PLAY;
            end
            S_PLAY: begin
                // Ground outranks a simultaneous touch fault.
                if (ev[4]) begin
                    award    = 1'b1;
                    award_p2 = (ball_xpos < NET_L);
                end else if (ev[2] && !ev[3]) begin
                    t1_d = t1_inc[2:0];
                    t2_d = 3'd0;
                    if (t1_inc > MAXT_L) begin
                        award    = 1'b1;
                        award_p2 = 1'b1;
                    end
                end else if (ev[3] && !ev[2]) begin
                    t2_d = t2_inc[2:0];
                    t1_d = 3'd0;
                    if (t2_inc > MAXT_L) award = 1'b1;
                end
                if (award) state_d = S_POINT;
            end
            S_POINT: begin
                if (pause_q == '0)
                    state_d = ((scorer_q ? s2_q : s1_q) == WIN_L) ? S_OVER : S_SERVE;
            end
            S_OVER: begin
                if (ev[0] || ev[1]) state_d = S_SERVE;
            end
            default: state_d = S_SERVE;
        endcase
    end

    always_ff @(posedge pclk) begin
        if (!rst) begin
            state_q  <= S_SERVE;
            t1_q     <= 3'd0;
            t2_q     <= 3'd0;
            pause_q  <= '0;
            s1_q     <= 5'd0;
            s2_q     <= 5'd0;
            serve_q  <= 1'b0;
            scorer_q <= 1'b0;
            winner_q <= 1'b0;
            pulse_q  <= 1'b0;
            hist_q   <= 5'd0;
        end else begin
            state_q <= state_d;
            hist_q  <= now;
            pulse_q <= award;
            if (state_q == S_SERVE && state_d == S_PLAY) begin
                t1_q <= 3'd0;
                t2_q <= 3'd0;
            end
            if (state_q == S_PLAY) begin
                t1_q <= t1_d;
                t2_q <= t2_d;
                if (award) begin
                    scorer_q <= award_p2;
                    serve_q  <= award_p2;
                    pause_q  <= PAUSE_L;
                    if (award_p2 && s2_q < WIN_L) s2_q <= s2_q + 5'd1;
                    if (!award_p2 && s1_q < WIN_L) s1_q <= s1_q + 5'd1;
                end
            end
            if (state_q == S_POINT) begin
                if (frame_tick && pause_q != '0) pause_q <= pause_q - 1'b1;
                if (state_d == S_OVER) winner_q <= scorer_q;
            end
            if (state_q == S_OVER && state_d == S_SERVE) begin
                s1_q    <= 5'd0;
                s2_q    <= 5'd0;
                serve_q <= ~winner_q;
            end
        end
    end

    // point_pulse is a one-cycle strobe with no back-pressure; scores and
    // serve_side already hold their new values in the same cycle.
    assign state       = state_q;
    assign ball_hold   = (state_q == S_SERVE) || (state_q == S_OVER);
    assign ball_freeze = (state_q == S_POINT);
    assign serve_side  = serve_q;
    assign serve_posx  = serve_q ? 12'(P2_SERVE_X) : 12'(P1_SERVE_X);
    assign score_p1    = s1_q;
    assign score_p2    = s2_q;
    assign point_pulse = pulse_q;
    assign endgame     = (state_q == S_OVER);
    assign winner      = winner_q;

endmodule
